// File: rtl/adder_arbiter_if.sv
// Request/response bundle for adder_arbiter: NREQ valid/ready request channels
// plus one tagged valid/ready response channel.
interface adder_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 3,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_carry;
    logic                  rsp_ovf;
    logic [IDW-1:0]        rsp_id;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_ovf, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_ovf, rsp_id
    );
endinterface

// File: rtl/adder_arbiter.sv
// One WIDTH-bit adder shared round-robin between NREQ requesters, 1-cycle latency.
// Define ADDER_ARB_SATURATE_EN to clamp rsp_sum on signed overflow.
module adder_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 3,
    parameter int IDW   = 2
) (
    input logic            clk,
    input logic            rst,
    adder_arbiter_if.slave bus
);
    typedef enum logic {IDLE, FULL} state_t;

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   gidx;
    logic             found;
    logic             accept;
    logic             xfer;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   sum_raw;
    logic [WIDTH-1:0] sum_out;
    logic             ovf;

    // A full register can take a new result only when it drains on the same edge.
    assign accept = (state == IDLE) || bus.rsp_ready;

    // Lowest valid index at or above rr_ptr wins; otherwise wrap to lowest valid overall.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                found = 1'b1;
                gidx  = IDW'(i);
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i] && (IDW'(i) >= rr_ptr))
                gidx = IDW'(i);
        end
    end

    assign xfer = !rst && accept && found;

    always_comb begin
        bus.req_ready = '0;
        op_a          = '0;
        op_b          = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_ready[i] = xfer && (gidx == IDW'(i));
            if (gidx == IDW'(i)) begin
                op_a = bus.req_a[i*WIDTH +: WIDTH];
                op_b = bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign sum_raw = {1'b0, op_a} + {1'b0, op_b};
    assign ovf     = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum_raw[WIDTH-1] != op_a[WIDTH-1]);

    always_comb begin
        sum_out = sum_raw[WIDTH-1:0];
`ifdef ADDER_ARB_SATURATE_EN
        // Overflow direction follows the common operand sign.
        if (ovf)
            sum_out = op_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_sum   <= '0;
            bus.rsp_carry <= 1'b0;
            bus.rsp_ovf   <= 1'b0;
            bus.rsp_id    <= '0;
        end else if (xfer) begin
            state         <= FULL;
            bus.rsp_valid <= 1'b1;
            bus.rsp_sum   <= sum_out;
            bus.rsp_carry <= sum_raw[WIDTH];
            bus.rsp_ovf   <= ovf;
            bus.rsp_id    <= gidx;
            rr_ptr        <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + IDW'(1);
        end else if (state == FULL && bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized + directed bench for adder_arbiter against a cycle-level reference model.
module tb_adder_arbiter;
    localparam int W  = 32;
    localparam int N  = 3;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adder_arbiter_if #(.WIDTH(W), .NREQ(N), .IDW(IW)) bus ();
    adder_arbiter #(.WIDTH(W), .NREQ(N), .IDW(IW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    bit         m_valid = 0;
    logic [W-1:0] m_sum = '0;
    bit         m_carry = 0;
    bit         m_ovf   = 0;
    int         m_id    = 0;
    int         m_ptr   = 0;
    bit         took    = 0;
    int         g_idx   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic grant(output bit f, output int idx);
        logic [N-1:0] v;
        v   = bus.req_valid;
        f   = 0;
        idx = 0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (!f && (((v >> j) & N'(1)) != '0)) begin
                f   = 1;
                idx = j;
            end
        end
    endtask

    // Golden addition from integer arithmetic on the operand values.
    task automatic model_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] s;
        longint ss, lim;
        s   = {32'b0, a} + {32'b0, b};
        ss  = longint'($signed(a)) + longint'($signed(b));
        lim = longint'(1) <<< (W - 1);
        m_carry = s[W];
        m_ovf   = (ss >= lim) || (ss < -lim);
        m_sum   = s[W-1:0];
`ifdef ADDER_ARB_SATURATE_EN
        if (m_ovf) m_sum = (ss > 0) ? W'(lim - 1) : W'(-lim);
`endif
    endtask

    task automatic cyc();
        logic [N-1:0] er;
        logic [W-1:0] a, b;
        bit acc, f;
        #1;
        grant(f, g_idx);
        acc = !m_valid || bus.rsp_ready;
        er  = '0;
        if (!rst && acc && f) er = N'(1) << g_idx;
        chk("req_ready", 64'(bus.req_ready), 64'(er));
        a = W'(bus.req_a >> (g_idx * W));
        b = W'(bus.req_b >> (g_idx * W));
        @(posedge clk);
        took = 0;
        if (rst) begin
            m_valid = 0; m_sum = '0; m_carry = 0; m_ovf = 0; m_id = 0; m_ptr = 0;
        end else if (acc && f) begin
            model_add(a, b);
            m_valid = 1;
            m_id    = g_idx;
            m_ptr   = (g_idx + 1) % N;
            took    = 1;
        end else if (m_valid && bus.rsp_ready) begin
            m_valid = 0;
        end
        @(negedge clk);
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_valid));
        chk("rsp_sum",   64'(bus.rsp_sum),   64'(m_sum));
        chk("rsp_carry", 64'(bus.rsp_carry), 64'(m_carry));
        chk("rsp_ovf",   64'(bus.rsp_ovf),   64'(m_ovf));
        chk("rsp_id",    64'(bus.rsp_id),    64'(m_id));
    endtask

    task automatic req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_valid = bus.req_valid | (N'(1) << i);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
    endtask

    task automatic drop(input int i);
        bus.req_valid = bus.req_valid & ~(N'(1) << i);
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return W'(1);
            2: return {1'b0, {(W-1){1'b1}}};
            3: return {1'b1, {(W-1){1'b0}}};
            4: return '1;
            default: return W'($urandom);
        endcase
    endfunction

    logic [W-1:0] ca [5] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678};
    logic [W-1:0] cb [5] = '{32'h0000_0001, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000};

    initial begin
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);

        // reset with requests pending: no grant while rst, then lowest valid index wins
        req(0, 32'd10, 32'd20);
        req(2, 32'd1, 32'd1);
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        chk("first_gnt_id", 64'(bus.rsp_id), 64'd0);
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        cyc();

        // single requester
        req(1, 32'd2, 32'd3);
        cyc();
        chk("single_sum", 64'(bus.rsp_sum), 64'd5);
        chk("single_id", 64'(bus.rsp_id), 64'd1);
        drop(1);
        cyc();

        // arithmetic corners
        for (int k = 0; k < 5; k++) begin
            bus.req_valid = '0;
            req(0, ca[k], cb[k]);
            cyc();
        end
        bus.req_valid = '0;
        cyc();

        // round robin, back-to-back
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < N; i++) req(i, W'(i * 100), W'(i + 1));
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("rr_id", 64'(bus.rsp_id), 64'(k % N));
            chk("rr_valid", 64'(bus.rsp_valid), 64'd1);
        end

        // backpressure with req0 and req2
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        cyc();
        req(0, 32'd7, 32'd8);
        req(2, 32'd9, 32'd9);
        bus.rsp_ready = 1'b1;
        cyc();
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) cyc();
        bus.rsp_ready = 1'b1;
        cyc();
        chk("bp_next_id", 64'(bus.rsp_id), 64'd2);

        // drain and refill on the same edge
        bus.req_valid = '0;
        req(1, 32'hFFFF_FFF0, 32'h20);
        cyc();
        chk("refill_id", 64'(bus.rsp_id), 64'd1);
        bus.req_valid = '0;
        cyc();
        chk("drain_valid", 64'(bus.rsp_valid), 64'd0);

        // reset while holding a result
        bus.rsp_ready = 1'b0;
        req(0, 32'd40, 32'd2);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.req_valid = '0;
        chk("rst_mid_sum", 64'(bus.rsp_sum), 64'd0);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            rst           = ($urandom_range(0, 59) == 0);
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++)
                if (((bus.req_valid >> i) & N'(1)) == '0 && $urandom_range(0, 1) == 1)
                    req(i, rnd_op(), rnd_op());
            cyc();
            if (took) drop(g_idx);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
